// File: rtl/spr_rf_pkg.sv
// -----------------------------------------------------------------------------
// spr_rf_pkg
// Shared constants and types for the scoreboarded register file (reg_file_sb),
// its bus interface and its read-port sub-module.
//
// Contents:
//   RF_ZERO_ADDR  address of the hard-wired zero register
//   RF_DW         default data width
//   RF_NREG       default register count
//   RF_AW         address width for the default register count
//   rf_addr_t     register address type for the default configuration
// -----------------------------------------------------------------------------
package spr_rf_pkg;

   localparam int RF_ZERO_ADDR = 0;
   localparam int RF_DW        = 16;
   localparam int RF_NREG      = 16;
   localparam int RF_AW        = $clog2(RF_NREG);

   typedef logic [RF_AW-1:0] rf_addr_t;

endpackage : spr_rf_pkg

// File: rtl/reg_file_sb_if.sv
// -----------------------------------------------------------------------------
// reg_file_sb_if
// Bus bundle between the core (master) and the scoreboarded register file
// (slave). DW and NREG must match the parameters of the attached reg_file_sb.
//
// Signals (master view):
//   RADDR1/RADDR2  out  read port addresses
//   RDATA1/RDATA2  in   read port data (combinational)
//   RBUSY1/RBUSY2  in   read port register pending (combinational)
//   WRV/WADDR/WDATA out writeback valid / address / data
//   ISS_V/ISS_ADDR out  issue request and destination register
//   ISS_RDY        in   issue may be accepted this cycle
//   PCNT           in   number of registers currently pending
// -----------------------------------------------------------------------------
interface reg_file_sb_if
   import spr_rf_pkg::*;
#(
   parameter int DW   = RF_DW,
   parameter int NREG = RF_NREG,
   localparam int AW  = $clog2(NREG)
);

   logic [AW-1:0] RADDR1;
   logic [AW-1:0] RADDR2;
   logic [DW-1:0] RDATA1;
   logic [DW-1:0] RDATA2;
   logic          RBUSY1;
   logic          RBUSY2;
   logic          WRV;
   logic [AW-1:0] WADDR;
   logic [DW-1:0] WDATA;
   logic          ISS_V;
   logic [AW-1:0] ISS_ADDR;
   logic          ISS_RDY;
   logic [AW:0]   PCNT;

   modport master (
      output RADDR1, RADDR2, WRV, WADDR, WDATA, ISS_V, ISS_ADDR,
      input  RDATA1, RDATA2, RBUSY1, RBUSY2, ISS_RDY, PCNT
   );

   modport slave (
      input  RADDR1, RADDR2, WRV, WADDR, WDATA, ISS_V, ISS_ADDR,
      output RDATA1, RDATA2, RBUSY1, RBUSY2, ISS_RDY, PCNT
   );

endinterface : reg_file_sb_if

// File: rtl/reg_file_sb_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file: selects data and pending
// flag for an address, forces the zero register, and optionally forwards the
// writeback of the current cycle.
//
// Ports:
//   raddr  in   read address
//   regs   in   flattened register array
//   pend   in   pending vector
//   wrv    in   writeback valid
//   waddr  in   writeback address
//   wdata  in   writeback data
//   rdata  out  read data
//   rbusy  out  register pending
// -----------------------------------------------------------------------------
module rf_read_port
   import spr_rf_pkg::*;
#(
   parameter int DW     = RF_DW,
   parameter int NREG   = RF_NREG,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic [AW-1:0]            raddr,
   input  logic [NREG-1:0][DW-1:0]  regs,
   input  logic [NREG-1:0]          pend,
   input  logic                     wrv,
   input  logic [AW-1:0]            waddr,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic                     rbusy
);

   logic is_zero;
   logic byp_hit;

   assign is_zero = (raddr == AW'(RF_ZERO_ADDR));
   // A writeback to this address in the same cycle supplies the data and
   // clears the busy indication before the array itself has been updated.
   assign byp_hit = (BYPASS != 0) && wrv && (waddr == raddr);

   always_comb begin
      rdata = regs[raddr];
      rbusy = pend[raddr];
      if (is_zero) begin
         rdata = '0;
         rbusy = 1'b0;
      end else if (byp_hit) begin
         rdata = wdata;
         rbusy = 1'b0;
      end
   end

endmodule : rf_read_port

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Two-read / one-write register file with a per-register pending scoreboard.
// Decode marks a destination pending at issue; writeback clears it. Register 0
// reads as zero and is never pending. With BYPASS=1 a writeback in the current
// cycle is visible on the read ports and on ISS_RDY in that same cycle.
//
// Ports:
//   CLK  in     clock, all state updates on the rising edge
//   RST  in     asynchronous active-high reset of data, pending bits and PCNT
//   bus  slave  read ports, writeback, issue handshake and pending count
//               (see reg_file_sb_if; its DW/NREG must match this module)
// -----------------------------------------------------------------------------
module reg_file_sb
   import spr_rf_pkg::*;
#(
   parameter int DW     = RF_DW,
   parameter int NREG   = RF_NREG,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic          CLK,
   input  logic          RST,
   reg_file_sb_if.slave  bus
);

   logic [NREG-1:0][DW-1:0] regs_reg;
   logic [NREG-1:0]         pend_reg;
   logic [NREG-1:0]         pend_next;
   logic [AW:0]             pcnt_reg;
   logic [AW:0]             pcnt_next;

   logic wr_hit;
   logic iss_rdy;
   logic iss_set;
   logic pend_inc;
   logic pend_dec;

   logic [AW-1:0] raddr_arr [2];
   logic [DW-1:0] rdata_arr [2];
   logic          rbusy_arr [2];

   // ---------------------------------------------------------------- write
   assign wr_hit = bus.WRV && (bus.WADDR != AW'(RF_ZERO_ADDR));

   // ---------------------------------------------------------------- issue
   // Ready when the destination is free, is r0, or is being released by a
   // bypassed writeback this cycle. Deliberately independent of ISS_V so the
   // decode stage can evaluate hazards before asserting a request.
   assign iss_rdy = (bus.ISS_ADDR == AW'(RF_ZERO_ADDR))
                 || !pend_reg[bus.ISS_ADDR]
                 || ((BYPASS != 0) && bus.WRV && (bus.WADDR == bus.ISS_ADDR));

   assign iss_set = bus.ISS_V && iss_rdy && (bus.ISS_ADDR != AW'(RF_ZERO_ADDR));

   // Issue is applied after the writeback clear so that a collision on the
   // same register leaves it pending.
   always_comb begin
      pend_next = pend_reg;
      if (wr_hit) begin
         pend_next[bus.WADDR] = 1'b0;
      end
      if (iss_set) begin
         pend_next[bus.ISS_ADDR] = 1'b1;
      end
      pend_next[RF_ZERO_ADDR] = 1'b0;
   end

   // ---------------------------------------------------------------- count
   // Incremental population count. An issue only adds when it turns a free
   // register pending; a writeback only subtracts when it actually releases a
   // pending register that is not being re-marked on the same edge.
   assign pend_inc = iss_set && !pend_reg[bus.ISS_ADDR];
   assign pend_dec = wr_hit && pend_reg[bus.WADDR]
                  && !(iss_set && (bus.ISS_ADDR == bus.WADDR));

   always_comb begin
      pcnt_next = pcnt_reg;
      case ({pend_inc, pend_dec})
         2'b10:   pcnt_next = pcnt_reg + (AW+1)'(1);
         2'b01:   pcnt_next = pcnt_reg - (AW+1)'(1);
         default: pcnt_next = pcnt_reg;
      endcase
   end

   // ---------------------------------------------------------------- state
   // regs_reg[0] is never written, so it holds its reset value; the read
   // ports force zero for address 0 regardless.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         regs_reg <= '0;
         pend_reg <= '0;
         pcnt_reg <= '0;
      end else begin
         if (wr_hit) begin
            regs_reg[bus.WADDR] <= bus.WDATA;
         end
         pend_reg <= pend_next;
         pcnt_reg <= pcnt_next;
      end
   end

   // ---------------------------------------------------------------- reads
   assign raddr_arr[0] = bus.RADDR1;
   assign raddr_arr[1] = bus.RADDR2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         rf_read_port #(
            .DW     (DW),
            .NREG   (NREG),
            .BYPASS (BYPASS)
         ) u_rd (
            .raddr (raddr_arr[gi]),
            .regs  (regs_reg),
            .pend  (pend_reg),
            .wrv   (bus.WRV),
            .waddr (bus.WADDR),
            .wdata (bus.WDATA),
            .rdata (rdata_arr[gi]),
            .rbusy (rbusy_arr[gi])
         );
      end
   endgenerate

   assign bus.RDATA1  = rdata_arr[0];
   assign bus.RDATA2  = rdata_arr[1];
   assign bus.RBUSY1  = rbusy_arr[0];
   assign bus.RBUSY2  = rbusy_arr[1];
   assign bus.ISS_RDY = iss_rdy;
   assign bus.PCNT    = pcnt_reg;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed bench for reg_file_sb. Three instances share clock and reset:
//   u_dut_a  DW=16 NREG=16 BYPASS=1
//   u_dut_b  DW=16 NREG=16 BYPASS=0
//   u_dut_w  DW=32 NREG=32 BYPASS=1
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   reg_file_sb_if                        bus_a ();
   reg_file_sb_if                        bus_b ();
   reg_file_sb_if #(.DW(32), .NREG(32))  bus_w ();

   reg_file_sb #(.BYPASS(1)) u_dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
   reg_file_sb #(.BYPASS(0)) u_dut_b (.CLK(clk), .RST(rst), .bus(bus_b));
   reg_file_sb #(.DW(32), .NREG(32), .BYPASS(1)) u_dut_w (.CLK(clk), .RST(rst), .bus(bus_w));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus_a.WRV = 1'b0; bus_a.ISS_V = 1'b0;
      bus_b.WRV = 1'b0; bus_b.ISS_V = 1'b0;
      bus_w.WRV = 1'b0; bus_w.ISS_V = 1'b0;
   endtask

   task automatic init_all();
      bus_a.RADDR1 = '0; bus_a.RADDR2 = '0; bus_a.WADDR = '0; bus_a.WDATA = '0; bus_a.ISS_ADDR = '0;
      bus_b.RADDR1 = '0; bus_b.RADDR2 = '0; bus_b.WADDR = '0; bus_b.WDATA = '0; bus_b.ISS_ADDR = '0;
      bus_w.RADDR1 = '0; bus_w.RADDR2 = '0; bus_w.WADDR = '0; bus_w.WDATA = '0; bus_w.ISS_ADDR = '0;
      idle_all();
   endtask

   // ------------------------------------------------------------------ reset
   task automatic test_reset();
      init_all();
      bus_a.RADDR1 = 4'd5; bus_a.RADDR2 = 4'd7; bus_a.ISS_ADDR = 4'd7;
      #1 rst = 1'b1;
      #1;
      checks++; if (bus_a.RDATA1 !== 16'h0000) begin failures++; $display("FAIL por_rdata1 got=%h exp=%h", bus_a.RDATA1, 16'h0000); end
      checks++; if (bus_a.RBUSY2 !== 1'b0) begin failures++; $display("FAIL por_rbusy2 got=%b exp=%b", bus_a.RBUSY2, 1'b0); end
      checks++; if (bus_a.ISS_RDY !== 1'b1) begin failures++; $display("FAIL por_iss_rdy got=%b exp=%b", bus_a.ISS_RDY, 1'b1); end
      checks++; if (bus_a.PCNT !== 5'd0) begin failures++; $display("FAIL por_pcnt got=%0d exp=%0d", bus_a.PCNT, 0); end
      tick();
      rst = 1'b0;
      // write r5 and issue r7 together, then reset between edges
      bus_a.WRV = 1'b1; bus_a.WADDR = 4'd5; bus_a.WDATA = 16'h1234;
      bus_a.ISS_V = 1'b1; bus_a.ISS_ADDR = 4'd7;
      tick();
      idle_all();
      #1;
      checks++; if (bus_a.RDATA1 !== 16'h1234) begin failures++; $display("FAIL pre_rst_rdata1 got=%h exp=%h", bus_a.RDATA1, 16'h1234); end
      checks++; if (bus_a.RBUSY2 !== 1'b1) begin failures++; $display("FAIL pre_rst_rbusy2 got=%b exp=%b", bus_a.RBUSY2, 1'b1); end
      checks++; if (bus_a.ISS_RDY !== 1'b0) begin failures++; $display("FAIL pre_rst_iss_rdy got=%b exp=%b", bus_a.ISS_RDY, 1'b0); end
      rst = 1'b1;
      #1;
      checks++; if (bus_a.RDATA1 !== 16'h0000) begin failures++; $display("FAIL mid_rst_rdata1 got=%h exp=%h", bus_a.RDATA1, 16'h0000); end
      checks++; if (bus_a.RBUSY2 !== 1'b0) begin failures++; $display("FAIL mid_rst_rbusy2 got=%b exp=%b", bus_a.RBUSY2, 1'b0); end
      checks++; if (bus_a.PCNT !== 5'd0) begin failures++; $display("FAIL mid_rst_pcnt got=%0d exp=%0d", bus_a.PCNT, 0); end
      checks++; if (bus_a.ISS_RDY !== 1'b1) begin failures++; $display("FAIL mid_rst_iss_rdy got=%b exp=%b", bus_a.ISS_RDY, 1'b1); end
      #1 rst = 1'b0;
   endtask

   // ------------------------------------------------------------------ r0
   task automatic test_zero_reg();
      tick();
      bus_a.WRV = 1'b1; bus_a.WADDR = 4'd0; bus_a.WDATA = 16'hFFFF;
      bus_a.ISS_V = 1'b1; bus_a.ISS_ADDR = 4'd0; bus_a.RADDR1 = 4'd0;
      #1;
      checks++; if (bus_a.ISS_RDY !== 1'b1) begin failures++; $display("FAIL zero_iss_rdy got=%b exp=%b", bus_a.ISS_RDY, 1'b1); end
      checks++; if (bus_a.RDATA1 !== 16'h0000) begin failures++; $display("FAIL zero_bypass_rdata got=%h exp=%h", bus_a.RDATA1, 16'h0000); end
      tick();
      idle_all();
      #1;
      checks++; if (bus_a.RDATA1 !== 16'h0000) begin failures++; $display("FAIL zero_rdata got=%h exp=%h", bus_a.RDATA1, 16'h0000); end
      checks++; if (bus_a.RBUSY1 !== 1'b0) begin failures++; $display("FAIL zero_rbusy got=%b exp=%b", bus_a.RBUSY1, 1'b0); end
      checks++; if (bus_a.PCNT !== 5'd0) begin failures++; $display("FAIL zero_pcnt got=%0d exp=%0d", bus_a.PCNT, 0); end
   endtask

   // ------------------------------------------------------------------ scoreboard
   task automatic test_scoreboard();
      bus_a.ISS_V = 1'b1; bus_a.ISS_ADDR = 4'd3;
      tick();
      bus_a.ISS_V = 1'b0; bus_a.RADDR1 = 4'd3;
      #1;
      checks++; if (bus_a.RBUSY1 !== 1'b1) begin failures++; $display("FAIL sb_rbusy_set got=%b exp=%b", bus_a.RBUSY1, 1'b1); end
      checks++; if (bus_a.PCNT !== 5'd1) begin failures++; $display("FAIL sb_pcnt_1 got=%0d exp=%0d", bus_a.PCNT, 1); end
      checks++; if (bus_a.ISS_RDY !== 1'b0) begin failures++; $display("FAIL sb_iss_rdy_busy got=%b exp=%b", bus_a.ISS_RDY, 1'b0); end
      // a request while not ready must be ignored
      bus_a.ISS_V = 1'b1;
      tick();
      bus_a.ISS_V = 1'b0;
      #1;
      checks++; if (bus_a.PCNT !== 5'd1) begin failures++; $display("FAIL sb_stalled_issue_pcnt got=%0d exp=%0d", bus_a.PCNT, 1); end
      bus_a.WRV = 1'b1; bus_a.WADDR = 4'd3; bus_a.WDATA = 16'hBEEF;
      tick();
      idle_all();
      #1;
      checks++; if (bus_a.RBUSY1 !== 1'b0) begin failures++; $display("FAIL sb_rbusy_clr got=%b exp=%b", bus_a.RBUSY1, 1'b0); end
      checks++; if (bus_a.RDATA1 !== 16'hBEEF) begin failures++; $display("FAIL sb_rdata got=%h exp=%h", bus_a.RDATA1, 16'hBEEF); end
      checks++; if (bus_a.PCNT !== 5'd0) begin failures++; $display("FAIL sb_pcnt_0 got=%0d exp=%0d", bus_a.PCNT, 0); end
      checks++; if (bus_a.ISS_RDY !== 1'b1) begin failures++; $display("FAIL sb_iss_rdy_free got=%b exp=%b", bus_a.ISS_RDY, 1'b1); end
   endtask

   // ------------------------------------------------------------------ bypass
   task automatic test_bypass();
      bus_a.WRV = 1'b1; bus_a.WADDR = 4'd3; bus_a.WDATA = 16'h1111;
      bus_b.WRV = 1'b1; bus_b.WADDR = 4'd3; bus_b.WDATA = 16'h1111;
      tick();
      idle_all();
      bus_a.ISS_V = 1'b1; bus_a.ISS_ADDR = 4'd3;
      bus_b.ISS_V = 1'b1; bus_b.ISS_ADDR = 4'd3;
      tick();
      idle_all();
      bus_a.WRV = 1'b1; bus_a.WADDR = 4'd3; bus_a.WDATA = 16'hA5A5; bus_a.RADDR2 = 4'd3;
      bus_b.WRV = 1'b1; bus_b.WADDR = 4'd3; bus_b.WDATA = 16'hA5A5; bus_b.RADDR2 = 4'd3;
      #1;
      checks++; if (bus_a.RDATA2 !== 16'hA5A5) begin failures++; $display("FAIL byp1_rdata2 got=%h exp=%h", bus_a.RDATA2, 16'hA5A5); end
      checks++; if (bus_a.RBUSY2 !== 1'b0) begin failures++; $display("FAIL byp1_rbusy2 got=%b exp=%b", bus_a.RBUSY2, 1'b0); end
      checks++; if (bus_a.ISS_RDY !== 1'b1) begin failures++; $display("FAIL byp1_iss_rdy got=%b exp=%b", bus_a.ISS_RDY, 1'b1); end
      checks++; if (bus_b.RDATA2 !== 16'h1111) begin failures++; $display("FAIL byp0_rdata2 got=%h exp=%h", bus_b.RDATA2, 16'h1111); end
      checks++; if (bus_b.RBUSY2 !== 1'b1) begin failures++; $display("FAIL byp0_rbusy2 got=%b exp=%b", bus_b.RBUSY2, 1'b1); end
      checks++; if (bus_b.ISS_RDY !== 1'b0) begin failures++; $display("FAIL byp0_iss_rdy got=%b exp=%b", bus_b.ISS_RDY, 1'b0); end
      tick();
      idle_all();
      #1;
      checks++; if (bus_b.RDATA2 !== 16'hA5A5) begin failures++; $display("FAIL byp0_next_rdata2 got=%h exp=%h", bus_b.RDATA2, 16'hA5A5); end
      checks++; if (bus_b.RBUSY2 !== 1'b0) begin failures++; $display("FAIL byp0_next_rbusy2 got=%b exp=%b", bus_b.RBUSY2, 1'b0); end
      checks++; if (bus_b.PCNT !== 5'd0) begin failures++; $display("FAIL byp0_pcnt got=%0d exp=%0d", bus_b.PCNT, 0); end
      checks++; if (bus_a.PCNT !== 5'd0) begin failures++; $display("FAIL byp1_pcnt got=%0d exp=%0d", bus_a.PCNT, 0); end
   endtask

   // ------------------------------------------------------------------ collision
   task automatic test_collision();
      bus_a.ISS_V = 1'b1; bus_a.ISS_ADDR = 4'd9;
      tick();
      idle_all();
      bus_a.WRV = 1'b1; bus_a.WADDR = 4'd9; bus_a.WDATA = 16'h0042;
      bus_a.ISS_V = 1'b1; bus_a.ISS_ADDR = 4'd9; bus_a.RADDR1 = 4'd9;
      tick();
      idle_all();
      #1;
      checks++; if (bus_a.RDATA1 !== 16'h0042) begin failures++; $display("FAIL coll_rdata got=%h exp=%h", bus_a.RDATA1, 16'h0042); end
      checks++; if (bus_a.RBUSY1 !== 1'b1) begin failures++; $display("FAIL coll_rbusy got=%b exp=%b", bus_a.RBUSY1, 1'b1); end
      checks++; if (bus_a.PCNT !== 5'd1) begin failures++; $display("FAIL coll_pcnt got=%0d exp=%0d", bus_a.PCNT, 1); end
      bus_a.WRV = 1'b1; bus_a.WADDR = 4'd9; bus_a.WDATA = 16'h0043;
      tick();
      idle_all();
      #1;
      checks++; if (bus_a.PCNT !== 5'd0) begin failures++; $display("FAIL coll_release_pcnt got=%0d exp=%0d", bus_a.PCNT, 0); end
   endtask

   // ------------------------------------------------------------------ back to back
   task automatic test_back_to_back();
      logic [15:0] exp_b;
      for (int i = 1; i <= 4; i++) begin
         bus_a.WRV = 1'b1; bus_a.WADDR = 4'(i); bus_a.WDATA = 16'h1000 + 16'(i); bus_a.RADDR1 = 4'(i);
         bus_b.WRV = 1'b1; bus_b.WADDR = 4'(i); bus_b.WDATA = 16'h2000 + 16'(i); bus_b.RADDR1 = 4'(i);
         #1;
         exp_b = (i == 3) ? 16'hA5A5 : 16'h0000;
         checks++; if (bus_a.RDATA1 !== 16'h1000 + 16'(i)) begin failures++; $display("FAIL b2b_byp1_r%0d got=%h exp=%h", i, bus_a.RDATA1, 16'h1000 + 16'(i)); end
         checks++; if (bus_b.RDATA1 !== exp_b) begin failures++; $display("FAIL b2b_byp0_old_r%0d got=%h exp=%h", i, bus_b.RDATA1, exp_b); end
         tick();
      end
      idle_all();
      bus_a.RADDR1 = 4'd1; bus_a.RADDR2 = 4'd4;
      bus_b.RADDR1 = 4'd2; bus_b.RADDR2 = 4'd3;
      #1;
      checks++; if (bus_a.RDATA1 !== 16'h1001) begin failures++; $display("FAIL b2b_a_r1 got=%h exp=%h", bus_a.RDATA1, 16'h1001); end
      checks++; if (bus_a.RDATA2 !== 16'h1004) begin failures++; $display("FAIL b2b_a_r4 got=%h exp=%h", bus_a.RDATA2, 16'h1004); end
      checks++; if (bus_b.RDATA1 !== 16'h2002) begin failures++; $display("FAIL b2b_b_r2 got=%h exp=%h", bus_b.RDATA1, 16'h2002); end
      checks++; if (bus_b.RDATA2 !== 16'h2003) begin failures++; $display("FAIL b2b_b_r3 got=%h exp=%h", bus_b.RDATA2, 16'h2003); end
   endtask

   // ------------------------------------------------------------------ full scoreboard
   task automatic test_full_scoreboard();
      for (int i = 1; i <= 31; i++) begin
         bus_w.ISS_V = 1'b1; bus_w.ISS_ADDR = 5'(i);
         tick();
      end
      idle_all();
      bus_w.ISS_ADDR = 5'd5;
      #1;
      checks++; if (bus_w.PCNT !== 6'd31) begin failures++; $display("FAIL full_pcnt got=%0d exp=%0d", bus_w.PCNT, 31); end
      checks++; if (bus_w.ISS_RDY !== 1'b0) begin failures++; $display("FAIL full_iss_rdy_r5 got=%b exp=%b", bus_w.ISS_RDY, 1'b0); end
      bus_w.ISS_ADDR = 5'd0;
      #1;
      checks++; if (bus_w.ISS_RDY !== 1'b1) begin failures++; $display("FAIL full_iss_rdy_r0 got=%b exp=%b", bus_w.ISS_RDY, 1'b1); end
      // write and re-issue r1 on the same edge
      bus_w.WRV = 1'b1; bus_w.WADDR = 5'd1; bus_w.WDATA = 32'hDEAD_0001;
      bus_w.ISS_V = 1'b1; bus_w.ISS_ADDR = 5'd1;
      tick();
      idle_all();
      bus_w.RADDR1 = 5'd1;
      #1;
      checks++; if (bus_w.PCNT !== 6'd31) begin failures++; $display("FAIL full_coll_pcnt got=%0d exp=%0d", bus_w.PCNT, 31); end
      checks++; if (bus_w.RBUSY1 !== 1'b1) begin failures++; $display("FAIL full_coll_rbusy got=%b exp=%b", bus_w.RBUSY1, 1'b1); end
      checks++; if (bus_w.RDATA1 !== 32'hDEAD_0001) begin failures++; $display("FAIL full_coll_rdata got=%h exp=%h", bus_w.RDATA1, 32'hDEAD_0001); end
      bus_w.WRV = 1'b1; bus_w.WADDR = 5'd31; bus_w.WDATA = 32'hCAFE_001F;
      tick();
      idle_all();
      bus_w.RADDR2 = 5'd31;
      #1;
      checks++; if (bus_w.PCNT !== 6'd30) begin failures++; $display("FAIL full_wr31_pcnt got=%0d exp=%0d", bus_w.PCNT, 30); end
      checks++; if (bus_w.RBUSY2 !== 1'b0) begin failures++; $display("FAIL full_wr31_rbusy got=%b exp=%b", bus_w.RBUSY2, 1'b0); end
      checks++; if (bus_w.RDATA2 !== 32'hCAFE_001F) begin failures++; $display("FAIL full_wr31_rdata got=%h exp=%h", bus_w.RDATA2, 32'hCAFE_001F); end
      // release r2 while marking r31: count is unchanged
      bus_w.WRV = 1'b1; bus_w.WADDR = 5'd2; bus_w.WDATA = 32'h0000_0002;
      bus_w.ISS_V = 1'b1; bus_w.ISS_ADDR = 5'd31;
      tick();
      idle_all();
      bus_w.RADDR1 = 5'd2;
      #1;
      checks++; if (bus_w.PCNT !== 6'd30) begin failures++; $display("FAIL full_cancel_pcnt got=%0d exp=%0d", bus_w.PCNT, 30); end
      checks++; if (bus_w.RBUSY1 !== 1'b0) begin failures++; $display("FAIL full_cancel_r2 got=%b exp=%b", bus_w.RBUSY1, 1'b0); end
      checks++; if (bus_w.RBUSY2 !== 1'b1) begin failures++; $display("FAIL full_cancel_r31 got=%b exp=%b", bus_w.RBUSY2, 1'b1); end
   endtask

   initial begin
      test_reset();
      test_zero_reg();
      test_scoreboard();
      test_bypass();
      test_collision();
      test_back_to_back();
      test_full_scoreboard();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the processor's two-read/one-write register file, generalised in data width and register count. It adds asynchronous reset of the whole array, optional write-to-read bypass, and a per-register pending scoreboard. Decode marks a destination register pending at issue; writeback clears it. The core uses the busy flags and issue-ready signal to stall on RAW/WAW hazards. Register 0 reads as zero and is never pending.

Parameters:
DW, 16, data width of each register
NREG, 16, number of registers; power of two, >= 4
AW, $clog2(NREG), address width (derived, not overridden)
BYPASS, 1, 1 = same-cycle writeback data/clear visible on read ports; 0 = visible next cycle

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
RADDR1  input  AW  read port 1 address
RADDR2  input  AW  read port 2 address
RDATA1  output  DW  read port 1 data (combinational)
RDATA2  output  DW  read port 2 data (combinational)
RBUSY1  output  1  register at RADDR1 pending (combinational)
RBUSY2  output  1  register at RADDR2 pending (combinational)
WRV  input  1  writeback valid
WADDR  input  AW  writeback address
WDATA  input  DW  writeback data
ISS_V  input  1  issue request: mark ISS_ADDR pending
ISS_ADDR  input  AW  destination register of issuing instruction
ISS_RDY  output  1  issue may be accepted this cycle (combinational)
PCNT  output  AW+1  number of registers currently pending

Behaviour:
- Reset: clock is CLK; reset is asynchronous and active-high on RST. Asserting RST immediately clears every register to 0, every pending bit to 0, and PCNT to 0. It overrides any write or issue in progress. Outputs are then RDATA*=0, RBUSY*=0, ISS_RDY=1.
- Register 0: writes ignored; reads return 0; pending bit constant 0; issue to address 0 accepted but has no effect.
- Write: on a rising edge with WRV=1 and WADDR!=0, regs[WADDR]<=WDATA and pend[WADDR]<=0. A write to a non-pending register is legal and still updates data.
- Read, combinational:
  - RDATAn = 0 if RADDRn==0.
  - Else, if BYPASS=1 and WRV and WADDR==RADDRn, RDATAn = WDATA.
  - Else RDATAn = regs[RADDRn].
  - RBUSYn follows the same rule: 0 for address 0, 0 under bypass match, otherwise pend[RADDRn].
- Issue ready: ISS_RDY = (ISS_ADDR==0) | !pend[ISS_ADDR] | (BYPASS & WRV & WADDR==ISS_ADDR). ISS_RDY is independent of ISS_V.
- Issue accept: ISS_V & ISS_RDY on a rising edge sets pend[ISS_ADDR]<=1 when ISS_ADDR!=0. ISS_V with ISS_RDY=0 is ignored: no state change; the requester holds.
- Simultaneous write and accepted issue to the same nonzero address: data is written and the pending bit ends set (issue wins).
- PCNT: registered population count of pend[]. It updates on the same edge as the pending bits:
  - +1 for an accepted issue to a non-pending nonzero register.
  - -1 for a write clearing a pending register.
  - Net 0 when both events hit the same register or cancel across registers.
  - Never exceeds NREG-1; never wraps below 0.
- Latency: write visible on reads at the same cycle's combinational outputs (BYPASS=1) or the next cycle (BYPASS=0). Pending set is visible the cycle after issue.

Decomposition:
- Shared package spr_rf_pkg holds:
  - constant RF_ZERO_ADDR = 0
  - localparam defaults RF_DW=16, RF_NREG=16
  - typedef rf_addr_t (logic [AW-1:0])
- One natural sub-module, rf_read_port: a combinational mux with zero-register forcing and bypass. It produces RDATA/RBUSY from address, array, pending vector and write-port signals, and is instantiated twice. The scoreboard and PCNT stay in the top module.

Test Plan:
- Reset mid-operation: write 0x1234 to r5 and issue r7, then pulse RST between edges -> RDATA1(r5)=0 and RBUSY(r7)=0 immediately, PCNT=0, ISS_RDY=1.
- Zero register: WRV=1, WADDR=0, WDATA=0xFFFF; ISS_V to r0 -> RDATA(r0)=0, RBUSY=0, PCNT stays 0.
- Scoreboard: issue r3 -> next cycle RBUSY1(r3)=1, PCNT=1; ISS_ADDR=3 gives ISS_RDY=0; write r3=0xBEEF -> next cycle RBUSY=0, RDATA=0xBEEF, PCNT=0.
- Bypass (BYPASS=1): r3 pending; same cycle WRV, WADDR=3, WDATA=0xA5A5 with RADDR2=3 -> RDATA2=0xA5A5, RBUSY2=0, ISS_RDY=1 for r3. With BYPASS=0 -> old data, RBUSY2=1, ISS_RDY=0.
- Collision: r9 pending; write r9=0x0042 and issue r9 on the same edge -> RDATA(r9)=0x0042, RBUSY=1, PCNT unchanged.
- Full scoreboard with DW=32, NREG=32: issue r1..r31 -> PCNT=31; write r1 while issuing r1 -> PCNT stays 31; write r31 alone -> PCNT=30.
